// File: rtl/fetch_pkg.sv
// Shared sizing, FSM encoding and address helpers for the instruction fetch buffer.
package fetch_pkg;

    localparam int LINE_BYTES   = 64;
    localparam int BUF_BYTES    = 128;
    localparam int WINDOW_BYTES = 15;

    localparam int CNT_W      = $clog2(BUF_BYTES + 1);
    localparam int BUF_IDX_W  = $clog2(BUF_BYTES);
    localparam int LINE_IDX_W = $clog2(LINE_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } fetch_state_t;

    function automatic logic [63:0] line_align(input logic [63:0] addr);
        return addr & ~64'(LINE_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_byte_queue.sv
// Byte shift queue: head always at index 0; pop and append in the same cycle, one-cycle update.
// No backpressure of its own: the owner only appends a line when it is known to fit.
module fetch_byte_queue
    import fetch_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [CNT_W-1:0]          pop_n,
    input  logic                      app_vld,
    input  logic [CNT_W-1:0]          app_offset,
    input  logic [LINE_IDX_W-1:0]     app_skip,
    input  logic [LINE_BYTES*8-1:0]   app_dat,
    output logic [CNT_W-1:0]          count,
    output logic [0:WINDOW_BYTES*8-1] head_dat
);

    logic [7:0]       mem_q [BUF_BYTES];
    logic [7:0]       mem_d [BUF_BYTES];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] app_len;

    assign app_len = app_vld ? (CNT_W'(LINE_BYTES) - CNT_W'(app_skip)) : '0;
    assign count   = count_q;

    always_comb begin : next_state
        int src;
        int k;
        src     = 0;
        k       = 0;
        mem_d   = mem_q;
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            for (int i = 0; i < BUF_BYTES; i++) begin
                src      = i + int'(pop_n);
                mem_d[i] = (src < BUF_BYTES) ? mem_q[src[BUF_IDX_W-1:0]] : 8'h00;
            end
            // New line bytes land right behind whatever survives this cycle's pop.
            if (app_vld) begin
                for (int i = 0; i < BUF_BYTES; i++) begin
                    k = i - int'(app_offset) + int'(app_skip);
                    if ((i >= int'(app_offset)) && (k < LINE_BYTES)) begin
                        mem_d[i] = app_dat[k*8 +: 8];
                    end
                end
            end
            count_d = count_q - pop_n + app_len;
        end
    end

    always_comb begin
        head_dat = '0;
        for (int j = 0; j < WINDOW_BYTES; j++) begin
            head_dat[8*j +: 8] = mem_q[j];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < BUF_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer between I-cache and decoder; window valid the cycle after the filling line returns.
// A line is requested only when it fits with zero consumption; the decoder stalls by withholding dc_if.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      set_rip,
    input  logic [63:0]               new_rip,
    output logic                      icache_enable,
    output logic [63:0]               icache_addr,
    input  logic [LINE_BYTES*8-1:0]   icache_rdata,
    input  logic                      icache_done,
    output logic [0:WINDOW_BYTES*8-1] decode_bytes,
    output logic [63:0]               decode_rip,
    input  logic [7:0]                bytes_decoded,
    output logic                      if_dc,
    input  logic                      dc_if
);

    fetch_state_t          state_q, state_d;
    logic                  enable_q, enable_d;
    logic [63:0]           addr_q, addr_d;
    logic [63:0]           rip_q, rip_d;
    logic [63:0]           fetch_addr_q, fetch_addr_d;
    logic                  first_q, first_d;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      pop_n;
    logic [CNT_W-1:0]      app_offset;
    logic [LINE_IDX_W-1:0] app_skip;
    logic                  consume;
    logic                  app_vld;

    assign if_dc      = (count >= CNT_W'(WINDOW_BYTES));
    assign consume    = dc_if && if_dc && !set_rip;
    assign pop_n      = consume ? CNT_W'(bytes_decoded) : '0;
    // A redirect kills any line returning in the same cycle.
    assign app_vld    = (state_q == REQ) && icache_done && !set_rip;
    assign app_skip   = first_q ? rip_q[LINE_IDX_W-1:0] : '0;
    assign app_offset = count - pop_n;

    fetch_byte_queue u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (set_rip),
        .pop_n      (pop_n),
        .app_vld    (app_vld),
        .app_offset (app_offset),
        .app_skip   (app_skip),
        .app_dat    (icache_rdata),
        .count      (count),
        .head_dat   (decode_bytes)
    );

    always_comb begin
        state_d      = state_q;
        enable_d     = enable_q;
        addr_d       = addr_q;
        rip_d        = rip_q;
        fetch_addr_d = fetch_addr_q;
        first_d      = first_q;

        if (set_rip) begin
            rip_d        = new_rip;
            fetch_addr_d = line_align(new_rip);
            first_d      = 1'b1;
        end else begin
            if (consume) begin
                rip_d = rip_q + 64'(bytes_decoded);
            end
            if (app_vld) begin
                fetch_addr_d = fetch_addr_q + 64'(LINE_BYTES);
                first_d      = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (!set_rip && (count <= CNT_W'(BUF_BYTES - LINE_BYTES))) begin
                    state_d  = REQ;
                    enable_d = 1'b1;
                    addr_d   = fetch_addr_q;
                end
            end
            REQ: begin
                if (icache_done) begin
                    state_d  = IDLE;
                    enable_d = 1'b0;
                end else if (set_rip) begin
                    state_d = DRAIN;
                end
            end
            // The stale request must still complete before a new one may be issued.
            DRAIN: begin
                if (icache_done) begin
                    state_d  = IDLE;
                    enable_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                enable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            enable_q     <= 1'b0;
            addr_q       <= '0;
            rip_q        <= set_rip ? new_rip : '0;
            fetch_addr_q <= set_rip ? line_align(new_rip) : '0;
            first_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            enable_q     <= enable_d;
            addr_q       <= addr_d;
            rip_q        <= rip_d;
            fetch_addr_q <= fetch_addr_d;
            first_q      <= first_d;
        end
    end

    assign icache_enable = enable_q;
    assign icache_addr   = addr_q;
    assign decode_rip    = rip_q;

    always_ff @(posedge clk) begin
        if (!reset && dc_if) begin
            assert (if_dc && (bytes_decoded != 8'd0)
                    && (bytes_decoded <= 8'(WINDOW_BYTES))
                    && (CNT_W'(bytes_decoded) <= count));
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed table plus randomized run of fetch_buffer against a byte-queue reference model.
module tb_fetch_buffer;

    logic         clk;
    logic         reset;
    logic         set_rip;
    logic [63:0]  new_rip;
    logic         icache_enable;
    logic [63:0]  icache_addr;
    logic [511:0] icache_rdata;
    logic         icache_done;
    logic [0:119] decode_bytes;
    logic [63:0]  decode_rip;
    logic [7:0]   bytes_decoded;
    logic         if_dc;
    logic         dc_if;

    fetch_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .set_rip       (set_rip),
        .new_rip       (new_rip),
        .icache_enable (icache_enable),
        .icache_addr   (icache_addr),
        .icache_rdata  (icache_rdata),
        .icache_done   (icache_done),
        .decode_bytes  (decode_bytes),
        .decode_rip    (decode_rip),
        .bytes_decoded (bytes_decoded),
        .if_dc         (if_dc),
        .dc_if         (dc_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the byte window as a plain queue plus the outstanding request.
    logic [7:0]  mq [$];
    logic [63:0] m_rip, m_fa, m_addr;
    bit          m_busy, m_disc, m_first;

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24];
    endfunction

    function automatic logic [511:0] line_of(input logic [63:0] a);
        logic [63:0]  base;
        logic [511:0] r;
        base = a & ~64'h3F;
        r    = '0;
        for (int k = 0; k < 64; k++) r[8*k +: 8] = mem_byte(base + 64'(k));
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_win(input string nm, input logic [0:119] act, input logic [0:119] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance the model with the current inputs, clock the DUT, then compare.
    task automatic tick();
        int          pre_size;
        int          skip;
        logic [63:0] pre_fa;
        logic [63:0] rip_pre;
        bit          cons, fin, issue;
        logic [0:119] ew, mk;
        pre_size = mq.size();
        pre_fa   = m_fa;
        rip_pre  = m_rip;
        if (reset) begin
            mq.delete();
            m_busy  = 0;
            m_disc  = 0;
            m_first = 1;
            m_addr  = '0;
            m_rip   = set_rip ? new_rip : 64'h0;
            m_fa    = set_rip ? (new_rip & ~64'h3F) : 64'h0;
        end else begin
            cons  = dc_if && (pre_size >= 15) && !set_rip;
            fin   = m_busy && icache_done;
            issue = !m_busy && !set_rip && (pre_size <= 64);
            if (cons) begin
                for (int n = 0; n < int'(bytes_decoded); n++) void'(mq.pop_front());
                m_rip = m_rip + 64'(bytes_decoded);
            end
            if (fin) begin
                if (!m_disc && !set_rip) begin
                    skip = m_first ? int'(rip_pre[5:0]) : 0;
                    for (int k = skip; k < 64; k++) mq.push_back(mem_byte(m_addr + 64'(k)));
                    m_fa    = m_fa + 64'd64;
                    m_first = 0;
                end
                m_busy = 0;
            end
            if (set_rip) begin
                mq.delete();
                m_rip   = new_rip;
                m_fa    = new_rip & ~64'h3F;
                m_first = 1;
                m_disc  = m_busy;
            end
            if (issue) begin
                m_busy = 1;
                m_disc = 0;
                m_addr = pre_fa;
            end
        end
        @(posedge clk);
        #1;
        chk("m_en", icache_enable, m_busy);
        chk("m_addr", icache_addr, m_addr);
        chk("m_rip", decode_rip, m_rip);
        chk("m_if_dc", if_dc, mq.size() >= 15);
        if (mq.size() > 0) begin
            ew = '0;
            mk = '0;
            for (int j = 0; j < 15 && j < mq.size(); j++) begin
                ew[8*j +: 8] = mq[j];
                mk[8*j +: 8] = 8'hFF;
            end
            chk_win("m_window", decode_bytes & mk, ew);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        srip;
        logic [63:0] nrip;
        logic        dc;
        logic [7:0]  nb;
        logic        done;
        logic        een;
        logic [63:0] eaddr;
        logic [63:0] erip;
        logic        eif;
        logic [7:0]  eb0;
        logic [7:0]  eb14;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    initial begin
        int lines;
        int en_late;

        //          rst   srip  new_rip        dc    nb     done  en    addr           rip            if_dc b0     b14
        tbl[0]  = '{1'b1, 1'b1, 64'h40_0000, 1'b0, 8'd0,  1'b0, 1'b0, 64'h0,       64'h40_0000, 1'b0, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 1'b0, 64'h0,       1'b0, 8'd0,  1'b0, 1'b1, 64'h40_0000, 64'h40_0000, 1'b0, 8'h00, 8'h00};
        tbl[2]  = '{1'b0, 1'b0, 64'h0,       1'b0, 8'd0,  1'b1, 1'b0, 64'h40_0000, 64'h40_0000, 1'b1, 8'h00, 8'h0E};
        tbl[3]  = '{1'b0, 1'b0, 64'h0,       1'b1, 8'd5,  1'b0, 1'b1, 64'h40_0040, 64'h40_0005, 1'b1, 8'h05, 8'h13};
        tbl[4]  = '{1'b0, 1'b0, 64'h0,       1'b1, 8'd15, 1'b0, 1'b1, 64'h40_0040, 64'h40_0014, 1'b1, 8'h14, 8'h22};
        tbl[5]  = '{1'b0, 1'b0, 64'h0,       1'b0, 8'd0,  1'b1, 1'b0, 64'h40_0040, 64'h40_0014, 1'b1, 8'h14, 8'h22};
        tbl[6]  = '{1'b0, 1'b0, 64'h0,       1'b0, 8'd0,  1'b0, 1'b0, 64'h40_0040, 64'h40_0014, 1'b1, 8'h14, 8'h22};
        tbl[7]  = '{1'b0, 1'b0, 64'h0,       1'b1, 8'd15, 1'b0, 1'b0, 64'h40_0040, 64'h40_0023, 1'b1, 8'h23, 8'h31};
        tbl[8]  = '{1'b0, 1'b0, 64'h0,       1'b1, 8'd15, 1'b0, 1'b0, 64'h40_0040, 64'h40_0032, 1'b1, 8'h32, 8'h40};
        tbl[9]  = '{1'b0, 1'b0, 64'h0,       1'b1, 8'd15, 1'b0, 1'b0, 64'h40_0040, 64'h40_0041, 1'b1, 8'h41, 8'h4F};
        tbl[10] = '{1'b0, 1'b0, 64'h0,       1'b0, 8'd0,  1'b0, 1'b1, 64'h40_0080, 64'h40_0041, 1'b1, 8'h41, 8'h4F};
        tbl[11] = '{1'b0, 1'b0, 64'h0,       1'b0, 8'd0,  1'b0, 1'b1, 64'h40_0080, 64'h40_0041, 1'b1, 8'h41, 8'h4F};
        tbl[12] = '{1'b0, 1'b1, 64'h50_0010, 1'b0, 8'd0,  1'b0, 1'b1, 64'h40_0080, 64'h50_0010, 1'b0, 8'h00, 8'h00};
        tbl[13] = '{1'b0, 1'b0, 64'h0,       1'b0, 8'd0,  1'b0, 1'b1, 64'h40_0080, 64'h50_0010, 1'b0, 8'h00, 8'h00};
        tbl[14] = '{1'b0, 1'b0, 64'h0,       1'b0, 8'd0,  1'b1, 1'b0, 64'h40_0080, 64'h50_0010, 1'b0, 8'h00, 8'h00};
        tbl[15] = '{1'b0, 1'b0, 64'h0,       1'b0, 8'd0,  1'b0, 1'b1, 64'h50_0000, 64'h50_0010, 1'b0, 8'h00, 8'h00};
        tbl[16] = '{1'b0, 1'b0, 64'h0,       1'b0, 8'd0,  1'b1, 1'b0, 64'h50_0000, 64'h50_0010, 1'b1, 8'h10, 8'h1E};
        tbl[17] = '{1'b0, 1'b0, 64'h0,       1'b0, 8'd0,  1'b0, 1'b1, 64'h50_0040, 64'h50_0010, 1'b1, 8'h10, 8'h1E};
        tbl[18] = '{1'b0, 1'b1, 64'h40_0000, 1'b1, 8'd4,  1'b1, 1'b0, 64'h50_0040, 64'h40_0000, 1'b0, 8'h00, 8'h00};
        tbl[19] = '{1'b0, 1'b0, 64'h0,       1'b0, 8'd0,  1'b0, 1'b1, 64'h40_0000, 64'h40_0000, 1'b0, 8'h00, 8'h00};
        tbl[20] = '{1'b0, 1'b0, 64'h0,       1'b0, 8'd0,  1'b1, 1'b0, 64'h40_0000, 64'h40_0000, 1'b1, 8'h00, 8'h0E};
        tbl[21] = '{1'b0, 1'b1, 64'h40_003A, 1'b0, 8'd0,  1'b0, 1'b0, 64'h40_0000, 64'h40_003A, 1'b0, 8'h00, 8'h00};
        tbl[22] = '{1'b0, 1'b0, 64'h0,       1'b0, 8'd0,  1'b0, 1'b1, 64'h40_0000, 64'h40_003A, 1'b0, 8'h00, 8'h00};
        tbl[23] = '{1'b0, 1'b0, 64'h0,       1'b0, 8'd0,  1'b1, 1'b0, 64'h40_0000, 64'h40_003A, 1'b0, 8'h00, 8'h00};
        tbl[24] = '{1'b0, 1'b0, 64'h0,       1'b0, 8'd0,  1'b0, 1'b1, 64'h40_0040, 64'h40_003A, 1'b0, 8'h00, 8'h00};
        tbl[25] = '{1'b0, 1'b0, 64'h0,       1'b0, 8'd0,  1'b1, 1'b0, 64'h40_0040, 64'h40_003A, 1'b1, 8'h3A, 8'h48};
        tbl[26] = '{1'b0, 1'b0, 64'h0,       1'b0, 8'd0,  1'b0, 1'b0, 64'h40_0040, 64'h40_003A, 1'b1, 8'h3A, 8'h48};

        reset         = 1'b1;
        set_rip       = 1'b0;
        new_rip       = '0;
        dc_if         = 1'b0;
        bytes_decoded = '0;
        icache_done   = 1'b0;
        icache_rdata  = '0;
        m_rip = '0; m_fa = '0; m_addr = '0;
        m_busy = 0; m_disc = 0; m_first = 1;

        for (int i = 0; i < NV; i++) begin
            reset         = tbl[i].rst;
            set_rip       = tbl[i].srip;
            new_rip       = tbl[i].nrip;
            dc_if         = tbl[i].dc;
            bytes_decoded = tbl[i].nb;
            icache_done   = tbl[i].done;
            icache_rdata  = tbl[i].done ? line_of(icache_addr) : '0;
            tick();
            chk($sformatf("tbl%0d_en", i), icache_enable, tbl[i].een);
            chk($sformatf("tbl%0d_addr", i), icache_addr, tbl[i].eaddr);
            chk($sformatf("tbl%0d_rip", i), decode_rip, tbl[i].erip);
            chk($sformatf("tbl%0d_if_dc", i), if_dc, tbl[i].eif);
            if (tbl[i].eif) begin
                chk($sformatf("tbl%0d_b0", i), decode_bytes[0:7], tbl[i].eb0);
                chk($sformatf("tbl%0d_b14", i), decode_bytes[112:119], tbl[i].eb14);
            end
            if (tbl[i].rst) chk_win("reset_window", decode_bytes, '0);
        end
        reset = 1'b0; set_rip = 1'b0; dc_if = 1'b0; icache_done = 1'b0;

        // Decoder never consumes: two lines fill the queue, then fetching stops.
        set_rip = 1'b1;
        new_rip = 64'h1000;
        tick();
        set_rip = 1'b0;
        lines   = 0;
        en_late = 0;
        for (int c = 0; c < 40; c++) begin
            icache_done  = icache_enable;
            icache_rdata = icache_enable ? line_of(icache_addr) : '0;
            if (icache_enable) lines++;
            if (c >= 20 && icache_enable) en_late++;
            tick();
        end
        icache_done = 1'b0;
        chk("nocons_lines", 64'(lines), 64'd2);
        chk("nocons_late_enable", 64'(en_late), 64'd0);

        // Randomized traffic, including redirects near the top of the address space.
        for (int c = 0; c < 4000; c++) begin
            reset   = ($urandom_range(0, 599) == 0);
            set_rip = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 2))
                0:       new_rip = {$urandom, $urandom};
                1:       new_rip = 64'hFFFF_FFFF_FFFF_FF80 | 64'($urandom_range(0, 127));
                default: new_rip = 64'h40_0000 + 64'($urandom_range(0, 255));
            endcase
            dc_if         = (mq.size() >= 15) && ($urandom_range(0, 1) == 1);
            bytes_decoded = dc_if ? 8'($urandom_range(1, 15)) : 8'($urandom_range(0, 255));
            icache_done   = icache_enable && ($urandom_range(0, 2) == 0);
            icache_rdata  = icache_done ? line_of(icache_addr) : {16{$urandom}};
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction-fetch stage between the I-cache and the decoder.
- Fetches 64-byte lines from ICache and keeps a sliding byte window starting at the current decode RIP.
- Presents 15 bytes to the decoder and retires however many bytes the decoder consumed.
- Flushes and refetches when the core signals a redirect (reset, exe/wb branch).

Parameters:
- LINE_BYTES, 64, I-cache line size in bytes; power of two.
- BUF_BYTES, 128, byte-queue capacity; multiple of LINE_BYTES, ≥ 2*LINE_BYTES.
- WINDOW_BYTES, 15, bytes presented to the decoder (maximum x86 instruction length).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- set_rip  in  1  redirect request.
- new_rip  in  64  redirect target.
- icache_enable  out  1  line request.
- icache_addr  out  64  line-aligned request address.
- icache_rdata  in  512  line data; byte k = bits [8k+7:8k].
- icache_done  in  1  one-cycle pulse; icache_rdata valid that cycle.
- decode_bytes  out  [0:119]  window; bits [0:7] = byte at decode_rip.
- decode_rip  out  64  address of decode_bytes[0:7].
- bytes_decoded  in  8  bytes consumed when dc_if=1; legal range 1..15.
- if_dc  out  1  window valid (count ≥ WINDOW_BYTES).
- dc_if  in  1  decoder consumed bytes_decoded this cycle.

Behaviour:
- All state lives in registers. Outputs are driven from registers except if_dc, which is combinational from count.
- Reset values: icache_enable=0, icache_addr=0, decode_rip=0, count=0, fetch_addr=0, state=IDLE, decode_bytes=0.
- If reset and set_rip are high in the same cycle, decode_rip and fetch_addr take new_rip and new_rip&~63 respectively.
- States:
  - IDLE: if count ≤ BUF_BYTES-LINE_BYTES and not set_rip, go to REQ. Register icache_enable=1 and icache_addr=fetch_addr.
  - REQ: hold enable and address stable until icache_done.
    - On done, append bytes [skip..63], where skip = (first line after redirect) ? decode_rip[5:0] : 0.
    - Then fetch_addr += 64, enable goes to 0, next state IDLE.
  - DRAIN: entered when set_rip arrives while in REQ without done. Keep enable high and the old address. Discard data on done, then go to IDLE.
- Redirect (set_rip=1, any state):
  - count=0, decode_rip=new_rip, fetch_addr=new_rip&~63, first-line flag set.
  - Takes priority over a dc_if and over an icache_done in the same cycle; that cycle's data is discarded.
  - Receiving set_rip in DRAIN keeps the state at DRAIN and updates the target.
- Consume: when dc_if=1 and if_dc=1, decode_rip += bytes_decoded and the queue shifts by bytes_decoded.
  - dc_if while if_dc=0, or bytes_decoded > count, is illegal; add an assertion.
- Same-cycle append and consume: count' = count - bytes_decoded + appended. Appended bytes land at position count - bytes_decoded.
- Latency:
  - done at cycle N → if_dc at N+1 if count ≥ 15.
  - Redirect at cycle N → icache_enable at N+2, or later if draining.
- The queue never overflows: a request is issued only when a full line fits, even with zero consumption.
- Wrap-around: fetch_addr increments modulo 2^64 with no special handling.
- A 15-byte window spanning two lines is valid once both lines are queued.

Decomposition:
- Package fetch_pkg:
  - LINE_BYTES, WINDOW_BYTES, BUF_BYTES.
  - enum fetch_state_t {IDLE, REQ, DRAIN}.
  - Function line_align(addr).
- Sub-module fetch_byte_queue:
  - BUF_BYTES-entry byte shift queue with flush, append(offset, data, skip) and pop(n) ports.
  - Output: count plus the head WINDOW_BYTES bytes.
- The top level holds the FSM, RIP and fetch-address registers.

Test Plan:
- Reset with set_rip=1, new_rip=0x400000 → icache_addr=0x400000 and enable at cycle 2. After done with line bytes 0x00..0x3F: decode_bytes[0:7]=0x00, decode_rip=0x400000, if_dc=1.
- Redirect to 0x40003A: the first line supplies 6 bytes, so if_dc stays 0. After the second line (addr 0x400040) arrives, if_dc=1, decode_bytes[0:7]=0x3A, and bytes 6..14 come from the next line.
- Consume 5 then 15 bytes: decode_rip advances 0x400000→0x400005→0x400014, the window shifts accordingly, and a third line is requested once count ≤ 64.
- Decoder never consumes: exactly 2 lines are fetched (count=128), then icache_enable stays 0 indefinitely.
- set_rip=0x500010 while REQ is outstanding for 0x400080 → enable stays high with addr 0x400080 until done, data discarded, then request 0x500000. First valid byte is at offset 0x10.
- set_rip, icache_done and dc_if in the same cycle → buffer flushed, count=0, decode_rip=new_rip, returned line ignored.
